// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin two-way arbiter between the instruction-side (I)
// and data-side (D) requesters for the single cache-bus master port.
//
// Handshake: a requester raises *req_valid and holds it, with its command
// fields, until its own transaction completes (bus_ready && bus_last while it
// owns the bus). Once granted, the command is latched, so owner valid/command
// changes mid-transaction are ignored. bus_valid is a pure decode of the state
// register. There is always at least one IDLE cycle between two grants.
module cbus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ireq_valid,
   input  logic                ireq_is_write,
   input  logic [2:0]          ireq_size,
   input  logic [ADDR_W-1:0]   ireq_addr,
   input  logic [3:0]          ireq_len,
   input  logic [1:0]          ireq_burst,
   input  logic [DATA_W/8-1:0] ireq_strobe,
   input  logic [DATA_W-1:0]   ireq_data,
   input  logic                dreq_valid,
   input  logic                dreq_is_write,
   input  logic [2:0]          dreq_size,
   input  logic [ADDR_W-1:0]   dreq_addr,
   input  logic [3:0]          dreq_len,
   input  logic [1:0]          dreq_burst,
   input  logic [DATA_W/8-1:0] dreq_strobe,
   input  logic [DATA_W-1:0]   dreq_data,
   output logic                bus_valid,
   output logic                bus_is_write,
   output logic [2:0]          bus_size,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [3:0]          bus_len,
   output logic [1:0]          bus_burst,
   output logic [DATA_W/8-1:0] bus_strobe,
   output logic [DATA_W-1:0]   bus_data,
   input  logic                bus_ready,
   input  logic                bus_last,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                iresp_ready,
   output logic                iresp_last,
   output logic [DATA_W-1:0]   iresp_data,
   output logic                dresp_ready,
   output logic                dresp_last,
   output logic [DATA_W-1:0]   dresp_data,
   output logic                grant_i,
   output logic                grant_d,
   output logic [CNT_W-1:0]    icnt,
   output logic [CNT_W-1:0]    dcnt,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_last_owner;  // 0 = I, 1 = D
   logic                r_is_write;
   logic [2:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_len;
   logic [1:0]          r_burst;
   logic [CNT_W-1:0]    r_icnt;
   logic [CNT_W-1:0]    r_dcnt;
   logic                w_done;
   logic                w_grant_now;

   assign w_done      = bus_ready && bus_last;
   assign w_grant_now = (r_state == IDLE) && (w_next_state != IDLE);

   // Next-state: round-robin pick in IDLE, hold ownership until the final beat
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (ireq_valid && dreq_valid)
               w_next_state = r_last_owner ? BUSY_I : BUSY_D;
            else if (dreq_valid)
               w_next_state = BUSY_D;
            else if (ireq_valid)
               w_next_state = BUSY_I;
         end
         BUSY_I:  if (w_done) w_next_state = IDLE;
         BUSY_D:  if (w_done) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register, winner command latch and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b0;
         r_is_write   <= 1'b0;
         r_size       <= '0;
         r_addr       <= '0;
         r_len        <= '0;
         r_burst      <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_grant_now) begin
            if (w_next_state == BUSY_D) begin
               r_last_owner <= 1'b1;
               r_is_write   <= dreq_is_write;
               r_size       <= dreq_size;
               r_addr       <= dreq_addr;
               r_len        <= dreq_len;
               r_burst      <= dreq_burst;
            end else begin
               r_last_owner <= 1'b0;
               r_is_write   <= ireq_is_write;
               r_size       <= ireq_size;
               r_addr       <= ireq_addr;
               r_len        <= ireq_len;
               r_burst      <= ireq_burst;
            end
         end
      end
   end

   // Completed-transaction counters, bumped on the edge that returns to IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_icnt <= '0;
         r_dcnt <= '0;
      end else begin
         if (r_state == BUSY_I && w_done) r_icnt <= r_icnt + CNT_W'(1);
         if (r_state == BUSY_D && w_done) r_dcnt <= r_dcnt + CNT_W'(1);
      end
   end

   // Output decode: ownership, data pass-through and response routing
   always_comb begin
      bus_valid   = 1'b0;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      bus_strobe  = '0;
      bus_data    = '0;
      iresp_ready = 1'b0;
      iresp_last  = 1'b0;
      dresp_ready = 1'b0;
      dresp_last  = 1'b0;
      case (r_state)
         BUSY_I: begin
            bus_valid   = 1'b1;
            grant_i     = 1'b1;
            bus_strobe  = ireq_strobe;
            bus_data    = ireq_data;
            iresp_ready = bus_ready;
            iresp_last  = bus_last;
         end
         BUSY_D: begin
            bus_valid   = 1'b1;
            grant_d     = 1'b1;
            bus_strobe  = dreq_strobe;
            bus_data    = dreq_data;
            dresp_ready = bus_ready;
            dresp_last  = bus_last;
         end
         default: ;
      endcase
   end

   assign bus_is_write = r_is_write;
   assign bus_size     = r_size;
   assign bus_addr     = r_addr;
   assign bus_len      = r_len;
   assign bus_burst    = r_burst;
   assign iresp_data   = bus_rdata;
   assign dresp_data   = bus_rdata;
   assign icnt         = r_icnt;
   assign dcnt         = r_dcnt;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed table-driven bench for cbus_arbiter (CNT_W = 4),
// followed by hand-written sequences for alternation, async reset and wrap.
module tb_cbus_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam logic [31:0] I_DATA = 32'h1111_1111;
   localparam logic [31:0] D_DATA = 32'h2222_2222;
   localparam int NV = 20;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic                ireq_valid = 0, dreq_valid = 0;
   logic                ireq_is_write = 0, dreq_is_write = 1;
   logic [2:0]          ireq_size = 3'd2, dreq_size = 3'd2;
   logic [ADDR_W-1:0]   ireq_addr = '0, dreq_addr = '0;
   logic [3:0]          ireq_len = '0, dreq_len = '0;
   logic [1:0]          ireq_burst = 2'd1, dreq_burst = 2'd1;
   logic [DATA_W/8-1:0] ireq_strobe = 4'h3, dreq_strobe = 4'hc;
   logic [DATA_W-1:0]   ireq_data = I_DATA, dreq_data = D_DATA;
   logic                bus_valid, bus_is_write;
   logic [2:0]          bus_size;
   logic [ADDR_W-1:0]   bus_addr;
   logic [3:0]          bus_len;
   logic [1:0]          bus_burst;
   logic [DATA_W/8-1:0] bus_strobe;
   logic [DATA_W-1:0]   bus_data;
   logic                bus_ready = 0, bus_last = 0;
   logic [DATA_W-1:0]   bus_rdata = 32'ha5a5_5a5a;
   logic                iresp_ready, iresp_last, dresp_ready, dresp_last;
   logic [DATA_W-1:0]   iresp_data, dresp_data;
   logic                grant_i, grant_d;
   logic [CNT_W-1:0]    icnt, dcnt;
   logic [1:0]          dbg_state;

   cbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
      .ireq_addr(ireq_addr), .ireq_len(ireq_len), .ireq_burst(ireq_burst),
      .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
      .dreq_valid(dreq_valid), .dreq_is_write(dreq_is_write), .dreq_size(dreq_size),
      .dreq_addr(dreq_addr), .dreq_len(dreq_len), .dreq_burst(dreq_burst),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .bus_valid(bus_valid), .bus_is_write(bus_is_write), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_len(bus_len), .bus_burst(bus_burst),
      .bus_strobe(bus_strobe), .bus_data(bus_data),
      .bus_ready(bus_ready), .bus_last(bus_last), .bus_rdata(bus_rdata),
      .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
      .dresp_ready(dresp_ready), .dresp_last(dresp_last), .dresp_data(dresp_data),
      .grant_i(grant_i), .grant_d(grant_d), .icnt(icnt), .dcnt(dcnt),
      .dbg_state(dbg_state)
   );

   // ---------------- vector table ----------------
   typedef struct packed {
      logic        rst, iv, dv;
      logic [31:0] iaddr, daddr;
      logic [3:0]  ilen, dlen;
      logic        rdy, lst;
      logic        e_bv, e_gi, e_gd;
      logic [31:0] e_addr, e_data;
      logic        e_ir, e_il, e_dr, e_dl;
      logic [3:0]  e_icnt, e_dcnt;
   } vec_t;

   vec_t vecs [NV];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic vec_t mkv(input int rst, iv, dv, ia, da, il, dl, rdy, lst,
                                input int bv, gi, gd, ea, ed, ir, ilst, dr, dlst,
                                input int ic, dc);
      vec_t v;
      v.rst = 1'(rst);  v.iv = 1'(iv);  v.dv = 1'(dv);
      v.iaddr = 32'(ia); v.daddr = 32'(da);
      v.ilen = 4'(il);  v.dlen = 4'(dl);
      v.rdy = 1'(rdy);  v.lst = 1'(lst);
      v.e_bv = 1'(bv);  v.e_gi = 1'(gi); v.e_gd = 1'(gd);
      v.e_addr = 32'(ea); v.e_data = 32'(ed);
      v.e_ir = 1'(ir);  v.e_il = 1'(ilst); v.e_dr = 1'(dr); v.e_dl = 1'(dlst);
      v.e_icnt = 4'(ic); v.e_dcnt = 4'(dc);
      return v;
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset      = v.rst;
      ireq_valid = v.iv;
      dreq_valid = v.dv;
      ireq_addr  = v.iaddr;
      dreq_addr  = v.daddr;
      ireq_len   = v.ilen;
      dreq_len   = v.dlen;
      bus_ready  = v.rdy;
      bus_last   = v.lst;
   endtask

   task automatic check_vec(input int k, input vec_t v);
      check($sformatf("v%0d bus_valid", k),   32'(bus_valid),   32'(v.e_bv));
      check($sformatf("v%0d grant_i", k),     32'(grant_i),     32'(v.e_gi));
      check($sformatf("v%0d grant_d", k),     32'(grant_d),     32'(v.e_gd));
      check($sformatf("v%0d bus_addr", k),    bus_addr,         v.e_addr);
      check($sformatf("v%0d bus_data", k),    bus_data,         v.e_data);
      check($sformatf("v%0d iresp_ready", k), 32'(iresp_ready), 32'(v.e_ir));
      check($sformatf("v%0d iresp_last", k),  32'(iresp_last),  32'(v.e_il));
      check($sformatf("v%0d dresp_ready", k), 32'(dresp_ready), 32'(v.e_dr));
      check($sformatf("v%0d dresp_last", k),  32'(dresp_last),  32'(v.e_dl));
      check($sformatf("v%0d icnt", k),        32'(icnt),        32'(v.e_icnt));
      check($sformatf("v%0d dcnt", k),        32'(dcnt),        32'(v.e_dcnt));
   endtask

   // expected grant pattern {grant_i, grant_d} for the alternation sequence
   logic [1:0] exp_q[$];

   // ---------------- test ----------------
   initial begin
      //           rst iv dv iaddr   daddr   il dl rdy lst | bv gi gd addr    data      ir il dr dl ic dc
      // D alone, len 0, completes in its first BUSY cycle
      vecs[0]  = mkv(0, 0, 1, 0,      'h1000, 0, 0, 0, 0,   0, 0, 0, 0,      0,        0, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(0, 0, 1, 0,      'h1000, 0, 0, 1, 1,   1, 0, 1, 'h1000, D_DATA,   0, 0, 1, 1, 0, 0);
      vecs[2]  = mkv(0, 0, 0, 0,      'h1000, 0, 0, 0, 0,   0, 0, 0, 'h1000, 0,        0, 0, 0, 0, 0, 1);
      // reset, then both request with len 3: D wins the first tie
      vecs[3]  = mkv(1, 0, 0, 0,      0,      0, 0, 0, 0,   0, 0, 0, 0,      0,        0, 0, 0, 0, 0, 0);
      vecs[4]  = mkv(0, 1, 1, 'h2000, 'h3000, 3, 3, 0, 0,   0, 0, 0, 0,      0,        0, 0, 0, 0, 0, 0);
      vecs[5]  = mkv(0, 1, 1, 'h2000, 'h3000, 3, 3, 1, 0,   1, 0, 1, 'h3000, D_DATA,   0, 0, 1, 0, 0, 0);
      vecs[6]  = mkv(0, 1, 1, 'h2000, 'h3000, 3, 3, 1, 0,   1, 0, 1, 'h3000, D_DATA,   0, 0, 1, 0, 0, 0);
      vecs[7]  = mkv(0, 1, 1, 'h2000, 'h3000, 3, 3, 1, 0,   1, 0, 1, 'h3000, D_DATA,   0, 0, 1, 0, 0, 0);
      vecs[8]  = mkv(0, 1, 1, 'h2000, 'h3000, 3, 3, 1, 1,   1, 0, 1, 'h3000, D_DATA,   0, 0, 1, 1, 0, 0);
      vecs[9]  = mkv(0, 1, 0, 'h2000, 'h3000, 3, 3, 0, 0,   0, 0, 0, 'h3000, 0,        0, 0, 0, 0, 0, 1);
      vecs[10] = mkv(0, 1, 0, 'h2000, 'h3000, 3, 3, 1, 0,   1, 1, 0, 'h2000, I_DATA,   1, 0, 0, 0, 0, 1);
      vecs[11] = mkv(0, 1, 0, 'h2000, 'h3000, 3, 3, 1, 0,   1, 1, 0, 'h2000, I_DATA,   1, 0, 0, 0, 0, 1);
      vecs[12] = mkv(0, 1, 0, 'h2000, 'h3000, 3, 3, 1, 0,   1, 1, 0, 'h2000, I_DATA,   1, 0, 0, 0, 0, 1);
      vecs[13] = mkv(0, 1, 0, 'h2000, 'h3000, 3, 3, 1, 1,   1, 1, 0, 'h2000, I_DATA,   1, 1, 0, 0, 0, 1);
      vecs[14] = mkv(0, 0, 0, 'h2000, 'h3000, 3, 3, 0, 0,   0, 0, 0, 'h2000, 0,        0, 0, 0, 0, 1, 1);
      // owner I drops valid and changes addr mid-transaction
      vecs[15] = mkv(0, 1, 0, 'h4000, 'h3000, 1, 0, 0, 0,   0, 0, 0, 'h2000, 0,        0, 0, 0, 0, 1, 1);
      vecs[16] = mkv(0, 0, 0, 'hdead, 'h3000, 1, 0, 0, 0,   1, 1, 0, 'h4000, I_DATA,   0, 0, 0, 0, 1, 1);
      vecs[17] = mkv(0, 0, 0, 'hdead, 'h3000, 1, 0, 1, 0,   1, 1, 0, 'h4000, I_DATA,   1, 0, 0, 0, 1, 1);
      vecs[18] = mkv(0, 0, 0, 'hdead, 'h3000, 1, 0, 1, 1,   1, 1, 0, 'h4000, I_DATA,   1, 1, 0, 0, 1, 1);
      vecs[19] = mkv(0, 0, 0, 'hdead, 'h3000, 0, 0, 0, 0,   0, 0, 0, 'h4000, 0,        0, 0, 0, 0, 2, 1);

      // reset phase: all outputs cleared
      #2;
      check("rst bus_valid", 32'(bus_valid), 32'd0);
      check("rst grant", 32'({grant_i, grant_d}), 32'd0);
      check("rst bus_addr", bus_addr, 32'd0);
      check("rst counters", 32'({icnt, dcnt}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      for (int k = 0; k < NV; k++) begin
         apply(vecs[k]);
         #1;
         check_vec(k, vecs[k]);
         tick();
      end

      // response data pass-through to both sides
      check("iresp_data", iresp_data, 32'ha5a5_5a5a);
      check("dresp_data", dresp_data, 32'ha5a5_5a5a);

      // alternation: both held, every BUSY cycle completes; last owner was I
      exp_q = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      ireq_valid = 1'b1; dreq_valid = 1'b1; bus_ready = 1'b1; bus_last = 1'b1;
      for (int c = 0; c < 8; c++) begin
         logic [1:0] exp_g;
         #1;
         exp_g = exp_q.pop_front();
         check($sformatf("alt c%0d grant", c), 32'({grant_i, grant_d}), 32'(exp_g));
         tick();
      end
      ireq_valid = 1'b0; dreq_valid = 1'b0; bus_ready = 1'b0; bus_last = 1'b0;
      #1;
      check("alt icnt", 32'(icnt), 32'd4);
      check("alt dcnt", 32'(dcnt), 32'd3);
      check("alt idle", 32'(bus_valid), 32'd0);
      tick();

      // async reset mid-beat in BUSY_D
      dreq_valid = 1'b1;
      tick();
      bus_ready = 1'b1; bus_last = 1'b0;
      #1;
      check("arst pre dresp_ready", 32'(dresp_ready), 32'd1);
      reset = 1'b1;
      #1;
      check("arst bus_valid", 32'(bus_valid), 32'd0);
      check("arst grant_d", 32'(grant_d), 32'd0);
      check("arst dresp_ready", 32'(dresp_ready), 32'd0);
      check("arst counters", 32'({icnt, dcnt}), 32'd0);
      tick();
      reset = 1'b0; dreq_valid = 1'b0; bus_ready = 1'b0;
      tick();

      // one D transaction, then 16 I transactions: icnt wraps, dcnt unchanged
      dreq_valid = 1'b1;
      tick();
      bus_ready = 1'b1; bus_last = 1'b1;
      tick();
      dreq_valid = 1'b0; bus_ready = 1'b0; bus_last = 1'b0;
      for (int t = 0; t < 16; t++) begin
         ireq_valid = 1'b1;
         tick();
         bus_ready = 1'b1; bus_last = 1'b1;
         tick();
         ireq_valid = 1'b0; bus_ready = 1'b0; bus_last = 1'b0;
         if (t == 14) check("wrap icnt 15", 32'(icnt), 32'd15);
      end
      #1;
      check("wrap icnt 0", 32'(icnt), 32'd0);
      check("wrap dcnt", 32'(dcnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Two-way arbiter sharing the core's single cache-bus master port between the instruction-side (I) and data-side (D) requesters of the mycpu pipeline. A requester holds its request until the granted transaction completes (`ready && last`). Those held requests are what raise `i_wait` and `d_wait` toward the pipeline. The block grants one requester at a time, latches its command fields, and routes bus responses back to the owner only. It also keeps per-side grant counters for performance monitoring.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `CNT_W`, 32, grant counter width
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `ireq_valid`, `dreq_valid`  in  1  request pending (held until own ready&&last)
- `ireq_is_write`, `dreq_is_write`  in  1  write command
- `ireq_size`, `dreq_size`  in  3  transfer size code
- `ireq_addr`, `dreq_addr`  in  ADDR_W  start address
- `ireq_len`, `dreq_len`  in  4  beats minus one
- `ireq_burst`, `dreq_burst`  in  2  burst type
- `ireq_strobe`, `dreq_strobe`  in  DATA_W/8  per-beat byte enables
- `ireq_data`, `dreq_data`  in  DATA_W  per-beat write data
- `bus_valid`  out  1  shared bus request valid
- `bus_is_write`, `bus_size`, `bus_addr`, `bus_len`, `bus_burst`  out  as above  latched command
- `bus_strobe`, `bus_data`  out  as above  pass-through from owner
- `bus_ready`, `bus_last`  in  1  beat accepted/returned, final beat
- `bus_rdata`  in  DATA_W  read data
- `iresp_ready`, `iresp_last`, `dresp_ready`, `dresp_last`  out  1  routed response
- `iresp_data`, `dresp_data`  out  DATA_W  `bus_rdata` pass-through
- `grant_i`, `grant_d`  out  1  one-hot ownership (both 0 in IDLE)
- `icnt`, `dcnt`  out  CNT_W  completed-transaction counters

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registers: `state`, `last_owner` (0=I, 1=D), latched command fields, `icnt`, `dcnt`.
- IDLE transitions:
  - only `dreq_valid` → BUSY_D.
  - only `ireq_valid` → BUSY_I.
  - both → grant the side that is not `last_owner` (round-robin).
  - neither → stay in IDLE.
- On leaving IDLE, latch the winner's is_write/size/addr/len/burst and set `last_owner` to the winner.
- BUSY_x:
  - `bus_valid=1`; command outputs come from the latch.
  - `bus_strobe`/`bus_data` come combinationally from owner x.
  - x response outputs: `xresp_ready=bus_ready`, `xresp_last=bus_last`.
  - Non-owner `ready`/`last` are 0. Both `*resp_data` always equal `bus_rdata`.
- BUSY_x with `bus_ready && bus_last` → IDLE on the next cycle, and the counter for x increments (wraps at 2^CNT_W).
- Owner deasserting valid mid-transaction is ignored. The latched command stays on the bus until last.
- Non-owner requests wait; their inputs have no effect on the bus.
- IDLE: `bus_valid=0`, all resp outputs 0, and command outputs hold their previous latched values.

## Timing
- Reset (async, immediate) clears:
  - `state` → IDLE, `last_owner` → I (D wins the first tie).
  - Latched fields → 0, counters → 0.
  - All outputs → 0.
- Reset mid-transaction drops `bus_valid` in the same cycle, with no completion or count.
- Arbitration latency: a request seen in IDLE at edge N drives `bus_valid` in cycle N+1.
- Back-to-back: after the last beat there is exactly one IDLE cycle before the next grant (≥1 bubble). A requester re-asserting immediately after its own last is still subject to round-robin against a waiting peer.
- Single-beat transaction (`len=0`, ready&&last in the first BUSY cycle): occupancy is 1 BUSY cycle + 1 IDLE cycle.
- `bus_valid` never depends combinationally on any `*req_valid`; it is a decode of `state` only.
- Counter update and state return happen on the same edge.

## Test plan
- Reset then `dreq_valid` alone, addr 0x1000, len 0; bus returns ready&&last in the next cycle:
  - `bus_valid` rises 1 cycle after request with `bus_addr=0x1000`.
  - `dresp_last=1` and `iresp_ready=0`.
  - `dcnt=1` and `grant_d` returns to 0.
- Both valid from reset, each len 3:
  - D granted first (4 beats); `iresp_ready` stays 0 throughout.
  - One IDLE cycle, then I granted; `icnt=1`, `dcnt=1`.
- D requests continuously while I waits:
  - Grants alternate D, I, D, I.
  - I never waits longer than one D transaction plus one bubble.
- Owner I drops `ireq_valid` and changes `ireq_addr` to 0xdead during BUSY_I:
  - `bus_addr` stays at the latched value until last.
  - FSM returns to IDLE only on `bus_last`.
- Async reset asserted mid-beat in BUSY_D:
  - `bus_valid`, `grant_d`, `dresp_ready` go to 0 before the next edge.
  - Counters read 0.
- With `CNT_W=4`, 16 completed I transactions → `icnt` wraps to 0 and `dcnt` is unchanged.
